// File: rtl/ip_packet_tx.sv
// Serialises one 36-byte Ethernet II / IPv4 frame that carries a 10-bit accelerator message.
// Addresses and the message are captured when the frame is accepted, and every output is registered.
module ip_packet_tx #(
  parameter logic [7:0] IP_TTL      = 8'h80,
  parameter logic [7:0] IP_PROTOCOL = 8'h04
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] ACCELERATOR_IP_ADDRESS,
  input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
  input  logic [31:0] RECIPIENT_IP_ADDRESS,
  input  logic [47:0] RECIPIENT_MAC_ADDRESS,
  input  logic [9:0]  RECIPIENT_MESSAGE,
  input  logic        START_IP_TXN,
  output logic        READY_FOR_SEND,
  output logic [7:0]  MAC_DATA_OUT,
  input  logic        MAC_DATA_READY,
  output logic        MAC_DATA_VALID,
  output logic        MAC_DATA_LAST,
  output logic        MAC_DATA_FIRST
);

  localparam logic [5:0] LAST_IDX = 6'd35;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [5:0]  idx;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [47:0] src_mac_q, dst_mac_q;
  logic [9:0]  msg_q;

  logic [31:0]  sum, fold1, fold2;
  logic [15:0]  csum;
  logic [287:0] frame;
  logic [5:0]   rev_idx;
  logic [7:0]   byte_sel;

  // The checksum word itself is left out of the sum; the other nine header words are fixed or captured.
  always_comb begin
    sum   = 32'h4500 + 32'h0016 + 32'h0000 + 32'h0000 + {16'h0, IP_TTL, IP_PROTOCOL}
          + {16'h0, src_ip_q[31:16]} + {16'h0, src_ip_q[15:0]}
          + {16'h0, dst_ip_q[31:16]} + {16'h0, dst_ip_q[15:0]};
    fold1 = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    fold2 = {16'h0, fold1[15:0]} + {16'h0, fold1[31:16]};
    csum  = ~fold2[15:0];
  end

  // The whole frame is one packed vector with byte 0 in the MSBs.
  always_comb begin
    frame    = {dst_mac_q, src_mac_q, 16'h0800,
                8'h45, 8'h00, 16'h0016, 16'h0000, 16'h0000,
                IP_TTL, IP_PROTOCOL, csum, src_ip_q, dst_ip_q,
                6'b0, msg_q};
    rev_idx  = LAST_IDX - idx;
    byte_sel = frame[{rev_idx, 3'b000} +: 8];
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state          <= IDLE;
      idx            <= '0;
      READY_FOR_SEND <= 1'b1;
      MAC_DATA_OUT   <= '0;
      MAC_DATA_VALID <= 1'b0;
      MAC_DATA_FIRST <= 1'b0;
      MAC_DATA_LAST  <= 1'b0;
      src_ip_q       <= '0;
      dst_ip_q       <= '0;
      src_mac_q      <= '0;
      dst_mac_q      <= '0;
      msg_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          MAC_DATA_OUT   <= '0;
          MAC_DATA_VALID <= 1'b0;
          MAC_DATA_FIRST <= 1'b0;
          MAC_DATA_LAST  <= 1'b0;
          READY_FOR_SEND <= 1'b1;
          idx            <= '0;
          if (START_IP_TXN) begin
            src_ip_q       <= ACCELERATOR_IP_ADDRESS;
            src_mac_q      <= ACCELERATOR_MAC_ADDRESS;
            dst_ip_q       <= RECIPIENT_IP_ADDRESS;
            dst_mac_q      <= RECIPIENT_MAC_ADDRESS;
            msg_q          <= RECIPIENT_MESSAGE;
            READY_FOR_SEND <= 1'b0;
            state          <= SEND;
          end
        end
        SEND: begin
          READY_FOR_SEND <= 1'b0;
          if (MAC_DATA_READY) begin
            MAC_DATA_OUT   <= byte_sel;
            MAC_DATA_VALID <= 1'b1;
            MAC_DATA_FIRST <= (idx == '0);
            MAC_DATA_LAST  <= (idx == LAST_IDX);
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              idx <= idx + 6'd1;
            end
          end else begin
            // A stall leaves a bubble on the output and keeps the index where it is.
            MAC_DATA_OUT   <= '0;
            MAC_DATA_VALID <= 1'b0;
            MAC_DATA_FIRST <= 1'b0;
            MAC_DATA_LAST  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_packet_tx.sv
// Bench for ip_packet_tx: directed and randomized frames with stalls, mid-frame disturbance and reset abort,
// compared against a byte-level frame model that computes an RFC 1071 header checksum.
module tb_ip_packet_tx;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic [31:0] ACCELERATOR_IP_ADDRESS = '0;
  logic [47:0] ACCELERATOR_MAC_ADDRESS = '0;
  logic [31:0] RECIPIENT_IP_ADDRESS = '0;
  logic [47:0] RECIPIENT_MAC_ADDRESS = '0;
  logic [9:0]  RECIPIENT_MESSAGE = '0;
  logic        START_IP_TXN = 1'b0;
  logic        READY_FOR_SEND;
  logic [7:0]  MAC_DATA_OUT;
  logic        MAC_DATA_READY = 1'b0;
  logic        MAC_DATA_VALID;
  logic        MAC_DATA_LAST;
  logic        MAC_DATA_FIRST;

  ip_packet_tx dut (
    .ACLK                    (ACLK),
    .ARESET                  (ARESET),
    .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
    .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
    .RECIPIENT_IP_ADDRESS    (RECIPIENT_IP_ADDRESS),
    .RECIPIENT_MAC_ADDRESS   (RECIPIENT_MAC_ADDRESS),
    .RECIPIENT_MESSAGE       (RECIPIENT_MESSAGE),
    .START_IP_TXN            (START_IP_TXN),
    .READY_FOR_SEND          (READY_FOR_SEND),
    .MAC_DATA_OUT            (MAC_DATA_OUT),
    .MAC_DATA_READY          (MAC_DATA_READY),
    .MAC_DATA_VALID          (MAC_DATA_VALID),
    .MAC_DATA_LAST           (MAC_DATA_LAST),
    .MAC_DATA_FIRST          (MAC_DATA_FIRST)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] s_ip, d_ip;
  logic [47:0] s_mac, d_mac;
  logic [9:0]  msg;
  logic [7:0]  exp_b [36];
  int          stalls [36];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference frame from field rules; checksum by summing header words until no carry remains.
  task automatic model_frame();
    int sum;
    logic [15:0] cs;
    for (int i = 0; i < 6; i++) exp_b[i]     = d_mac[8*(5-i) +: 8];
    for (int i = 0; i < 6; i++) exp_b[6+i]   = s_mac[8*(5-i) +: 8];
    exp_b[12] = 8'h08; exp_b[13] = 8'h00;
    exp_b[14] = 8'h45; exp_b[15] = 8'h00; exp_b[16] = 8'h00; exp_b[17] = 8'h16;
    for (int i = 18; i < 22; i++) exp_b[i] = 8'h00;
    exp_b[22] = 8'h80; exp_b[23] = 8'h04;
    exp_b[24] = 8'h00; exp_b[25] = 8'h00;
    for (int i = 0; i < 4; i++) exp_b[26+i] = s_ip[8*(3-i) +: 8];
    for (int i = 0; i < 4; i++) exp_b[30+i] = d_ip[8*(3-i) +: 8];
    exp_b[34] = {6'b0, msg[9:8]};
    exp_b[35] = msg[7:0];
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {exp_b[i], exp_b[i+1]};
    while ((sum >> 16) != 0) sum = (sum & 32'hffff) + (sum >> 16);
    cs = ~sum[15:0];
    exp_b[24] = cs[15:8];
    exp_b[25] = cs[7:0];
  endtask

  task automatic drive_cfg();
    ACCELERATOR_IP_ADDRESS  = s_ip;
    ACCELERATOR_MAC_ADDRESS = s_mac;
    RECIPIENT_IP_ADDRESS    = d_ip;
    RECIPIENT_MAC_ADDRESS   = d_mac;
    RECIPIENT_MESSAGE       = msg;
  endtask

  task automatic set_cfg_default();
    s_ip = 32'hbeefbeef; s_mac = 48'h54b00bedabba;
    d_ip = 32'hdeadbeef; d_mac = 48'h32dabbadebd5; msg = 10'h1ff;
  endtask

  // Entered and left just after a falling edge; ends with one idle cycle checked, so calls chain back-to-back.
  task automatic send_frame(input string name, input int disturb_at);
    model_frame();
    drive_cfg();
    chk({name, ".rdy_idle"}, READY_FOR_SEND, 1'b1);
    START_IP_TXN = 1'b1;
    @(negedge ACLK);
    START_IP_TXN = 1'b0;
    chk({name, ".rdy_busy"}, READY_FOR_SEND, 1'b0);
    chk({name, ".valid_accept"}, MAC_DATA_VALID, 1'b0);
    for (int k = 0; k < 36; k++) begin
      for (int s = 0; s < stalls[k]; s++) begin
        MAC_DATA_READY = 1'b0;
        @(negedge ACLK);
        chk({name, ".stall"}, {READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MAC_DATA_OUT}, '0);
      end
      if (k == disturb_at) begin
        START_IP_TXN = 1'b1;
        RECIPIENT_IP_ADDRESS = $urandom;
        RECIPIENT_MAC_ADDRESS = {$urandom, $urandom};
        RECIPIENT_MESSAGE = 10'($urandom);
        ACCELERATOR_IP_ADDRESS = $urandom;
      end
      MAC_DATA_READY = 1'b1;
      @(negedge ACLK);
      START_IP_TXN = 1'b0;
      chk({name, ".byte"}, {k[7:0], MAC_DATA_OUT}, {k[7:0], exp_b[k]});
      chk({name, ".flags"}, {READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST},
          {1'b0, 1'b1, (k == 0), (k == 35)});
    end
    MAC_DATA_READY = 1'($urandom);
    @(negedge ACLK);
    chk({name, ".end_valid"}, MAC_DATA_VALID, 1'b0);
    chk({name, ".end_rdy"}, READY_FOR_SEND, 1'b1);
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 36; i++) stalls[i] = 0;
  endtask

  initial begin
    set_cfg_default();
    drive_cfg();
    #12;
    chk("reset", {READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MAC_DATA_OUT}, {1'b1, 11'h0});
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("idle_rdy", READY_FOR_SEND, 1'b1);

    // Plain frame, then the stall pattern before bytes 4,5,6,7,20,33.
    clear_stalls();
    send_frame("t1", -1);
    stalls[4] = 1; stalls[5] = 2; stalls[6] = 3; stalls[7] = 4; stalls[20] = 5; stalls[33] = 6;
    send_frame("t2", -1);

    // Back-to-back frames.
    clear_stalls();
    send_frame("t3a", -1);
    send_frame("t3b", -1);

    // START and new inputs mid-frame must not change the frame in flight.
    send_frame("t4", 12);
    set_cfg_default();

    // Reset while byte 9 is on the output.
    model_frame();
    drive_cfg();
    START_IP_TXN = 1'b1;
    @(negedge ACLK);
    START_IP_TXN = 1'b0;
    MAC_DATA_READY = 1'b1;
    repeat (10) @(negedge ACLK);
    chk("t5.pre_byte", MAC_DATA_OUT, exp_b[9]);
    #2 ARESET = 1'b0;
    #1 chk("t5.abort", {READY_FOR_SEND, MAC_DATA_VALID, MAC_DATA_FIRST, MAC_DATA_LAST, MAC_DATA_OUT}, {1'b1, 11'h0});
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    send_frame("t5.resume", -1);

    // Alternate payload and destination.
    msg = 10'h2a5; d_ip = 32'h0a000001;
    send_frame("t6", -1);
    chk("t6.payload", {exp_b[34], exp_b[35]}, 16'h02a5);

    // Random addresses, messages and stalls.
    for (int f = 0; f < 8; f++) begin
      s_ip = $urandom; d_ip = $urandom;
      s_mac = {$urandom, $urandom}; d_mac = {$urandom, $urandom};
      msg = 10'($urandom);
      for (int i = 0; i < 36; i++)
        stalls[i] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 4) : 0;
      send_frame("rand", (f % 3 == 0) ? $urandom_range(1, 35) : -1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge ACLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
